// File: rtl/fetch_queue_pkg.sv
// Shared types for the F1->decode instruction buffer.
// Entry layout, queue geometry and pointer/count types.
package fetch_queue_pkg;

    localparam int FQ_DEPTH = 8;
    localparam int FQ_PTR_W = $clog2(FQ_DEPTH);

    typedef logic [FQ_PTR_W-1:0] fq_ptr_t;
    typedef logic [FQ_PTR_W:0]   fq_cnt_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] raw_instr;
        logic [7:0]  cp0_ctl;
        logic [1:0]  i_tlb_exc;
        logic        pre_b;
        logic [31:0] pre_pc;
    } fetch_data_t;

    // Number of present instructions in a fetched pair.
    function automatic logic [1:0] fq_pair_cnt(
        input fetch_data_t [1:0] d
    );
        return {1'b0, d[1].valid} + {1'b0, d[0].valid};
    endfunction

endpackage

// File: rtl/fetch_queue_ram.sv
// Entry storage for the fetch queue.
// Two write ports, two combinational read ports, no reset.
module fetch_queue_ram
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = FQ_DEPTH,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we_a_i,
    input  logic [PTR_W-1:0] wa_idx_i,
    input  fetch_data_t      wd_a_i,
    input  logic             we_b_i,
    input  logic [PTR_W-1:0] wb_idx_i,
    input  fetch_data_t      wd_b_i,
    input  logic [PTR_W-1:0] ra_idx_i,
    output fetch_data_t      rd_a_o,
    input  logic [PTR_W-1:0] rb_idx_i,
    output fetch_data_t      rd_b_o
);

    fetch_data_t mem_q [DEPTH];

    // Write up to two entries; the ports never target the same index.
    always_ff @(posedge clk) begin
        if (we_a_i) mem_q[wa_idx_i] <= wd_a_i;
        if (we_b_i) mem_q[wb_idx_i] <= wd_b_i;
    end

    assign rd_a_o = mem_q[ra_idx_i];
    assign rd_b_o = mem_q[rb_idx_i];

endmodule

// File: rtl/fetch_queue.sv
// Dual-issue instruction buffer between F1 and decode.
// Circular buffer; head pair shown to decode, older in slot 1.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = FQ_DEPTH,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              flush,
    input  fetch_data_t [1:0] in_data,
    output logic              in_ready,
    input  logic [1:0]        deq_cnt,
    output fetch_data_t [1:0] dataF2,
    output logic [PTR_W:0]    count
);

    localparam logic [PTR_W:0] CNT_LIM  = (PTR_W+1)'(DEPTH - 2);
    localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [PTR_W:0]   count_q, count_d;

    logic             enq;
    logic [1:0]       n_in;
    logic             we_a, we_b;
    logic [PTR_W-1:0] wa_idx, wb_idx;
    logic [PTR_W-1:0] rb_idx;
    fetch_data_t      rd_a, rd_b;

    assign n_in     = fq_pair_cnt(in_data);
    assign in_ready = (count_q <= CNT_LIM);
    assign enq      = in_ready & ~flush;

    // Compact valid slots: slot 1 at tail, slot 0 right after it.
    always_comb begin
        we_a   = enq & in_data[1].valid;
        we_b   = enq & in_data[0].valid;
        wa_idx = tail_q;
        wb_idx = tail_q + PTR_W'(in_data[1].valid);
    end

    // Pointer and occupancy update; redirect clears everything.
    always_comb begin
        head_d  = head_q + PTR_W'(deq_cnt);
        tail_d  = tail_q;
        count_d = count_q - (PTR_W+1)'(deq_cnt);
        if (enq) begin
            tail_d  = tail_q + PTR_W'(n_in);
            count_d = count_d + (PTR_W+1)'(n_in);
        end
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    // Queue state registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign rb_idx = head_q + PTR_W'(1);

    fetch_queue_ram #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_ram (
        .clk      (clk),
        .we_a_i   (we_a),
        .wa_idx_i (wa_idx),
        .wd_a_i   (in_data[1]),
        .we_b_i   (we_b),
        .wb_idx_i (wb_idx),
        .wd_b_i   (in_data[0]),
        .ra_idx_i (head_q),
        .rd_a_o   (rd_a),
        .rb_idx_i (rb_idx),
        .rd_b_o   (rd_b)
    );

    // Stored valid bits are stale; presence comes from occupancy.
    always_comb begin
        dataF2          = {rd_a, rd_b};
        dataF2[1].valid = (count_q != '0);
        dataF2[0].valid = (count_q >= (PTR_W+1)'(2));
    end

    assign count = count_q;

    a_deq_not3: assert property (
        @(posedge clk) disable iff (!resetn)
        deq_cnt != 2'd3
    );

    a_deq_avail: assert property (
        @(posedge clk) disable iff (!resetn)
        (PTR_W+1)'(deq_cnt) <= count_q
    );

    a_no_overflow: assert property (
        @(posedge clk) disable iff (!resetn)
        count_q <= CNT_FULL
    );

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for the fetch queue.
// One task per scenario, inline checks.
module tb_fetch_queue;
    import fetch_queue_pkg::*;

    logic              clk;
    logic              resetn;
    logic              flush;
    fetch_data_t [1:0] in_data;
    logic              in_ready;
    logic [1:0]        deq_cnt;
    fetch_data_t [1:0] dataF2;
    fq_cnt_t           count;

    int n_vec;
    int n_err;

    fetch_queue dut (
        .clk      (clk),
        .resetn   (resetn),
        .flush    (flush),
        .in_data  (in_data),
        .in_ready (in_ready),
        .deq_cnt  (deq_cnt),
        .dataF2   (dataF2),
        .count    (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic fetch_data_t mk(
        input logic        v,
        input logic [31:0] pc,
        input logic        pb,
        input logic [31:0] ppc
    );
        fetch_data_t d;
        d.valid     = v;
        d.pc        = pc;
        d.raw_instr = pc ^ 32'h1357_9BDF;
        d.cp0_ctl   = pc[9:2];
        d.i_tlb_exc = pc[3:2];
        d.pre_b     = pb;
        d.pre_pc    = ppc;
        return d;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put_pair(input logic [31:0] pc);
        in_data[1] = mk(1'b1, pc, 1'b0, 32'h0);
        in_data[0] = mk(1'b1, pc + 32'd4, 1'b0, 32'h0);
    endtask

    task automatic put_one(input logic [31:0] pc);
        in_data[1] = mk(1'b0, 32'h0, 1'b0, 32'h0);
        in_data[0] = mk(1'b1, pc, 1'b0, 32'h0);
    endtask

    task automatic put_none();
        in_data = '0;
    endtask

    task automatic test_reset();
        resetn  = 1'b0;
        flush   = 1'b0;
        deq_cnt = 2'd0;
        put_none();
        #12;
        n_vec++;
        if (count !== 4'd0) begin
            n_err++;
            $display("FAIL rst_count got=%0d exp=0", count);
        end
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL rst_ready got=%b exp=1", in_ready);
        end
        n_vec++;
        if ({dataF2[1].valid, dataF2[0].valid} !== 2'b00) begin
            n_err++;
            $display("FAIL rst_valid got=%b%b exp=00",
                     dataF2[1].valid, dataF2[0].valid);
        end
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_pair();
        fetch_data_t e1, e0;
        e1 = mk(1'b1, 32'hBFC0_0000, 1'b0, 32'h0);
        e0 = mk(1'b1, 32'hBFC0_0004, 1'b0, 32'h0);
        put_pair(32'hBFC0_0000);
        tick();
        put_none();
        n_vec++;
        if (dataF2[1] !== e1) begin
            n_err++;
            $display("FAIL pair_slot1 got=%h exp=%h", dataF2[1], e1);
        end
        n_vec++;
        if (dataF2[0] !== e0) begin
            n_err++;
            $display("FAIL pair_slot0 got=%h exp=%h", dataF2[0], e0);
        end
        n_vec++;
        if (count !== 4'd2) begin
            n_err++;
            $display("FAIL pair_count got=%0d exp=2", count);
        end
        deq_cnt = 2'd2;
        tick();
        deq_cnt = 2'd0;
        n_vec++;
        if (count !== 4'd0 || dataF2[1].valid !== 1'b0) begin
            n_err++;
            $display("FAIL pair_drain got=%0d/%b exp=0/0",
                     count, dataF2[1].valid);
        end
    endtask

    task automatic test_single();
        fetch_data_t e1;
        e1 = mk(1'b1, 32'h100, 1'b0, 32'h0);
        put_one(32'h100);
        tick();
        put_none();
        n_vec++;
        if (dataF2[1] !== e1) begin
            n_err++;
            $display("FAIL single_slot1 got=%h exp=%h", dataF2[1], e1);
        end
        n_vec++;
        if (dataF2[0].valid !== 1'b0) begin
            n_err++;
            $display("FAIL single_slot0v got=%b exp=0", dataF2[0].valid);
        end
        n_vec++;
        if (count !== 4'd1) begin
            n_err++;
            $display("FAIL single_count got=%0d exp=1", count);
        end
        deq_cnt = 2'd1;
        tick();
        deq_cnt = 2'd0;
        n_vec++;
        if (count !== 4'd0) begin
            n_err++;
            $display("FAIL single_drain got=%0d exp=0", count);
        end
    endtask

    task automatic test_full();
        for (int i = 0; i < 4; i++) begin
            put_pair(32'h1000 + 32'(8 * i));
            tick();
            n_vec++;
            if (count !== fq_cnt_t'(2 * i + 2)) begin
                n_err++;
                $display("FAIL full_fill%0d got=%0d exp=%0d",
                         i, count, 2 * i + 2);
            end
        end
        n_vec++;
        if (in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL full_ready got=%b exp=0", in_ready);
        end
        put_pair(32'hDEAD_0000);
        tick();
        put_none();
        n_vec++;
        if (count !== 4'd8 || dataF2[1].pc !== 32'h1000) begin
            n_err++;
            $display("FAIL full_hold got=%0d/%h exp=8/1000",
                     count, dataF2[1].pc);
        end
        deq_cnt = 2'd2;
        tick();
        n_vec++;
        if (count !== 4'd6 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL full_deq got=%0d/%b exp=6/1",
                     count, in_ready);
        end
        for (int k = 0; k < 3; k++) begin
            n_vec++;
            if (dataF2[1].pc !== 32'h1008 + 32'(8 * k) ||
                dataF2[0].pc !== 32'h100C + 32'(8 * k)) begin
                n_err++;
                $display("FAIL full_order%0d got=%h/%h exp=%h/%h", k,
                         dataF2[1].pc, dataF2[0].pc,
                         32'h1008 + 32'(8 * k), 32'h100C + 32'(8 * k));
            end
            tick();
        end
        deq_cnt = 2'd0;
        n_vec++;
        if (count !== 4'd0 || dataF2[1].valid !== 1'b0) begin
            n_err++;
            $display("FAIL full_empty got=%0d/%b exp=0/0",
                     count, dataF2[1].valid);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_q[$];
        logic [31:0] nxt;
        nxt = 32'h2000;
        put_pair(nxt);
        exp_q.push_back(nxt);
        exp_q.push_back(nxt + 32'd4);
        nxt = nxt + 32'd8;
        tick();
        for (int i = 0; i < 16; i++) begin
            if (i < 10) begin
                put_pair(nxt);
                deq_cnt = 2'd2;
                void'(exp_q.pop_front());
                void'(exp_q.pop_front());
                exp_q.push_back(nxt);
                exp_q.push_back(nxt + 32'd4);
                nxt = nxt + 32'd8;
            end else begin
                put_one(nxt);
                deq_cnt = 2'd1;
                void'(exp_q.pop_front());
                exp_q.push_back(nxt);
                nxt = nxt + 32'd4;
            end
            tick();
            n_vec++;
            if (dataF2[1].pc !== exp_q[0] ||
                dataF2[0].pc !== exp_q[1] ||
                count !== 4'd2) begin
                n_err++;
                $display("FAIL wrap%0d got=%h/%h/%0d exp=%h/%h/2", i,
                         dataF2[1].pc, dataF2[0].pc, count,
                         exp_q[0], exp_q[1]);
            end
        end
        put_none();
        deq_cnt = 2'd0;
    endtask

    task automatic test_flush();
        put_pair(32'h4000);
        tick();
        put_one(32'h4008);
        tick();
        n_vec++;
        if (count !== 4'd5) begin
            n_err++;
            $display("FAIL flush_pre got=%0d exp=5", count);
        end
        flush = 1'b1;
        put_pair(32'h5000);
        deq_cnt = 2'd2;
        tick();
        flush   = 1'b0;
        deq_cnt = 2'd0;
        put_none();
        n_vec++;
        if (count !== 4'd0 || in_ready !== 1'b1 ||
            {dataF2[1].valid, dataF2[0].valid} !== 2'b00) begin
            n_err++;
            $display("FAIL flush_clear got=%0d/%b/%b%b exp=0/1/00",
                     count, in_ready, dataF2[1].valid, dataF2[0].valid);
        end
        tick();
        n_vec++;
        if (count !== 4'd0) begin
            n_err++;
            $display("FAIL flush_stay got=%0d exp=0", count);
        end
        put_pair(32'h6000);
        tick();
        put_none();
        n_vec++;
        if (dataF2[1].pc !== 32'h6000 || dataF2[0].pc !== 32'h6004 ||
            count !== 4'd2) begin
            n_err++;
            $display("FAIL flush_after got=%h/%h/%0d exp=6000/6004/2",
                     dataF2[1].pc, dataF2[0].pc, count);
        end
        deq_cnt = 2'd2;
        tick();
        deq_cnt = 2'd0;
    endtask

    task automatic test_predict();
        fetch_data_t e1, e0;
        e1 = mk(1'b1, 32'h7000, 1'b1, 32'h200);
        e0 = mk(1'b1, 32'h7004, 1'b0, 32'h44);
        in_data[1] = e1;
        in_data[0] = e0;
        tick();
        put_none();
        n_vec++;
        if (dataF2[1] !== e1) begin
            n_err++;
            $display("FAIL pred_slot1 got=%h exp=%h", dataF2[1], e1);
        end
        n_vec++;
        if (dataF2[0] !== e0) begin
            n_err++;
            $display("FAIL pred_slot0 got=%h exp=%h", dataF2[0], e0);
        end
        deq_cnt = 2'd1;
        tick();
        deq_cnt = 2'd0;
        n_vec++;
        if (dataF2[1] !== e0 || dataF2[0].valid !== 1'b0 ||
            count !== 4'd1) begin
            n_err++;
            $display("FAIL pred_shift got=%h/%b/%0d exp=%h/0/1",
                     dataF2[1], dataF2[0].valid, count, e0);
        end
    endtask

    task automatic test_async_reset();
        put_pair(32'h8000);
        tick();
        put_none();
        n_vec++;
        if (count !== 4'd3) begin
            n_err++;
            $display("FAIL arst_pre got=%0d exp=3", count);
        end
        #3;
        resetn = 1'b0;
        #1;
        n_vec++;
        if (count !== 4'd0 || in_ready !== 1'b1 ||
            {dataF2[1].valid, dataF2[0].valid} !== 2'b00) begin
            n_err++;
            $display("FAIL arst_now got=%0d/%b/%b%b exp=0/1/00",
                     count, in_ready, dataF2[1].valid, dataF2[0].valid);
        end
        #2;
        resetn = 1'b1;
        put_pair(32'h9000);
        tick();
        put_none();
        n_vec++;
        if (dataF2[1].pc !== 32'h9000 || count !== 4'd2) begin
            n_err++;
            $display("FAIL arst_after got=%h/%0d exp=9000/2",
                     dataF2[1].pc, count);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_pair();
        test_single();
        test_full();
        test_wrap();
        test_flush();
        test_predict();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "bench timeout");
    end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Dual-issue instruction buffer between the I-cache response stage (F1) and decode.
- Accepts 0–2 fetched instructions per cycle and stores them in program order in a circular buffer.
- Presents the two oldest entries to decode as `dataF2[1:0]`; slot 1 holds the older instruction and slot 0 the younger.
- Decouples fetch bandwidth from issue bandwidth; all entries are discarded on pipeline redirect.

Parameters:
- DEPTH, 8, number of `fetch_data_t` entries; must be a power of two and at least 4.
- PTR_W, $clog2(DEPTH), width of the head and tail pointers.

Ports:
- clk  in  1  core clock.
- resetn  in  1  asynchronous, active-low reset.
- flush  in  1  redirect/exception; discard all contents.
- in_data  in  fetch_data_t[1:0]  fetched pair; slot 1 is older; per-slot `.valid` marks presence.
- in_ready  out  1  queue can accept a full pair this cycle.
- deq_cnt  in  2  number of entries consumed by decode/issue this cycle (0, 1 or 2).
- dataF2  out  fetch_data_t[1:0]  head entries; `dataF2[1]` = head, `dataF2[0]` = head+1.
- count  out  PTR_W+1  current occupancy.

Behaviour:
- State:
  - `mem[DEPTH]` of `fetch_data_t`.
  - `head` and `tail`, each PTR_W bits, wrapping modulo DEPTH.
  - `count`, PTR_W+1 bits.
- Reset (resetn=0, asynchronous):
  - head=0, tail=0, count=0.
  - Resulting outputs: `dataF2[1].valid=0`, `dataF2[0].valid=0`, in_ready=1.
  - mem contents are don't-care; nothing is forwarded from them because valid bits are derived from count.
- Readiness: in_ready = (DEPTH - count >= 2), combinational from registered count only.
- Enqueue, when in_ready=1:
  - n_in = `in_data[1].valid + in_data[0].valid`.
  - Valid slots are written compacted in order slot 1 then slot 0, starting at tail.
  - tail += n_in.
  - Case `in_data[1].valid=0`, `in_data[0].valid=1`: the slot-0 entry is written at tail.
- No enqueue when in_ready=0. F1 is responsible for holding its data; the queue ignores `in_data`.
- Dequeue:
  - head += deq_cnt, registered.
  - deq_cnt > number of valid outputs is illegal; flag it with an assertion.
  - deq_cnt=3 is illegal; flag it with an assertion.
- Output, combinational from registered state:
  - `dataF2[1] = mem[head]`, with `.valid = (count>=1)`.
  - `dataF2[0] = mem[head+1]` (index wraps), with `.valid = (count>=2)`.
  - All other fields (pc, raw_instr, cp0_ctl, i_tlb_exc, pre_b, pre_pc) pass through unmodified.
  - `pre_b`/`pre_pc` are meaningful on slot 1 only. Decode zeroes them on slot 0; the queue still stores them per entry.
- Latency:
  - An entry enqueued in cycle t is visible on dataF2 at cycle t+1 at the earliest.
  - There is no empty-queue bypass.
- Simultaneous enqueue and dequeue in one cycle:
  - count_next = count + n_in - deq_cnt.
  - Enqueue readiness is judged on pre-dequeue count, so conservative back-pressure is accepted.
- Flush:
  - Has priority over enqueue and dequeue in the same cycle.
  - Next cycle: head=tail=0, count=0, so both outputs are invalid next cycle.
  - `in_data` presented in the flush cycle is dropped.
- Wrap-around:
  - Pointer arithmetic is modulo DEPTH.
  - A pair written starting at DEPTH-1 occupies indices DEPTH-1 and 0.
- Full: count never exceeds DEPTH; assert this.
- Empty: count=0, outputs invalid, deq_cnt must be 0.

Decomposition:
- Shared package `cache_pkg` or `common` gains:
  - `FQ_DEPTH` constant.
  - `fq_ptr_t` typedef, `logic [PTR_W-1:0]`.
  - `fq_cnt_t` typedef, `logic [PTR_W:0]`.
- `fetch_data_t` is reused unchanged.
- One sub-module is natural: `fetch_queue_ram`.
  - 2 write ports with index+enable.
  - 2 combinational read ports.
  - Register array with no reset.
- Pointer, count and control logic stay in fetch_queue.

Test Plan:
1. Reset → outputs invalid, in_ready=1, count=0. Enqueue pair pc=0xBFC00000/0xBFC00004 → next cycle `dataF2[1].pc=0xBFC00000`, `dataF2[0].pc=0xBFC00004`, both valid, count=2.
2. Enqueue only slot 0 (pc=0x100), deq_cnt=0 → next cycle `dataF2[1].pc=0x100` valid, `dataF2[0].valid=0`, count=1.
3. DEPTH=8: enqueue 4 pairs with deq_cnt=0 → count=8, in_ready=0. A further pair offered is not written. Then deq_cnt=2 → count=6, in_ready=1.
4. Wrap: steady enqueue 2 / dequeue 2 for 10 cycles → outputs in strict PC order crossing index 7→0, count stays 2. Then deq_cnt=1 alternating → odd-aligned head; order is preserved.
5. Flush asserted with in pair valid and deq_cnt=2 at count=5 → next cycle count=0, outputs invalid. The flush-cycle pair never appears on dataF2.
6. Enqueue pair with `in_data[1].pre_b=1`, pre_pc=0x200 → appears on `dataF2[1]` with pre_b=1, pre_pc=0x200. After deq_cnt=1, the younger entry moves to slot 1 with its own stored pre_b. Asynchronous resetn pulse mid-stream → count=0 immediately, without waiting for a clock edge.
